// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared widths, ALU op encodings and forwarding-select type
package rv32_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_AW     = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_MEMWB,
        FWD_EXMEM
    } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - per-source RAW forwarding select and operand mux
module forward_unit
    import rv32_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] rs,
    input  logic [DW-1:0] rf_data,
    input  logic [AW-1:0] exmem_rd,
    input  logic          exmem_RegWrite,
    input  logic [DW-1:0] exmem_ALUout,
    input  logic [AW-1:0] memwb_rd,
    input  logic          memwb_RegWrite,
    input  logic [DW-1:0] memwb_Result,
    output logic [DW-1:0] data
);

    fwd_sel_t sel;

    // Youngest producer wins; x0 always reads the registered regfile value
    always_comb begin
        sel = FWD_RF;
        if (rs != '0 && exmem_RegWrite && exmem_rd == rs) begin
            sel = FWD_EXMEM;
        end else if (rs != '0 && memwb_RegWrite && memwb_rd == rs) begin
            sel = FWD_MEMWB;
        end
    end

    // Operand mux driven by the select above
    always_comb begin
        data = rf_data;
        case (sel)
            FWD_EXMEM: data = exmem_ALUout;
            FWD_MEMWB: data = memwb_Result;
            default:   data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register, hazard stall and forwarding (ID_EX_FORWARD_EN)
module id_ex_stage
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = rv32_pkg::DATA_WIDTH,
    parameter int REG_AW     = rv32_pkg::REG_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic [DATA_WIDTH-1:0] id_rd1,
    input  logic [DATA_WIDTH-1:0] id_rd2,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_ALUsrc,
    input  logic [2:0]            id_ALUctrl,
    input  logic                  id_RegWrite,
    input  logic                  id_MemRead,
    input  logic                  id_MemWrite,
    input  logic                  flush,
    input  logic [REG_AW-1:0]     exmem_rd,
    input  logic                  exmem_RegWrite,
    input  logic [DATA_WIDTH-1:0] exmem_ALUout,
    input  logic [REG_AW-1:0]     memwb_rd,
    input  logic                  memwb_RegWrite,
    input  logic [DATA_WIDTH-1:0] memwb_Result,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [2:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ex_StoreData,
    output logic                  ex_valid,
    output logic [REG_AW-1:0]     ex_rd,
    output logic                  ex_RegWrite,
    output logic                  ex_MemRead,
    output logic                  ex_MemWrite
);

    logic [DATA_WIDTH-1:0] ex_rd1;
    logic [DATA_WIDTH-1:0] ex_rd2;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic                  ex_ALUsrc;
    logic [DATA_WIDTH-1:0] op1_fwd;
    logic [DATA_WIDTH-1:0] op2_fwd;
    logic                  hazard;

`ifdef ID_EX_FORWARD_EN
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;

    // With forwarding only a load in EX cannot supply its result in time
    always_comb begin
        hazard = ex_MemRead && (ex_rd != '0) && id_valid &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    end
`else
    logic rs1_busy;
    logic rs2_busy;

    // Without forwarding any in-flight writer of a used source blocks ID
    always_comb begin
        rs1_busy = id_use_rs1 && (id_rs1 != '0) &&
                   ((ex_RegWrite    && ex_rd    == id_rs1) ||
                    (exmem_RegWrite && exmem_rd == id_rs1) ||
                    (memwb_RegWrite && memwb_rd == id_rs1));
        rs2_busy = id_use_rs2 && (id_rs2 != '0) &&
                   ((ex_RegWrite    && ex_rd    == id_rs2) ||
                    (exmem_RegWrite && exmem_rd == id_rs2) ||
                    (memwb_RegWrite && memwb_rd == id_rs2));
        hazard   = id_valid && (rs1_busy || rs2_busy);
    end
`endif

    assign stall = hazard && !flush;

    // EX register: reset, flush and hazard all load a bubble, otherwise capture ID
    always_ff @(posedge clk) begin
        if (rst || flush || hazard) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ALUctrl     <= ALU_ADD;
            ex_ALUsrc   <= 1'b0;
            ex_imm      <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
`ifdef ID_EX_FORWARD_EN
            ex_rs1      <= '0;
            ex_rs2      <= '0;
`endif
        end else begin
            ex_valid    <= id_valid;
            ex_rd       <= id_rd;
            ex_RegWrite <= id_RegWrite;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ALUctrl     <= id_ALUctrl;
            ex_ALUsrc   <= id_ALUsrc;
            ex_imm      <= id_imm;
            ex_rd1      <= id_rd1;
            ex_rd2      <= id_rd2;
`ifdef ID_EX_FORWARD_EN
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
`endif
        end
    end

`ifdef ID_EX_FORWARD_EN
    forward_unit #(.DW(DATA_WIDTH), .AW(REG_AW)) u_fwd_rs1 (
        .rs             (ex_rs1),
        .rf_data        (ex_rd1),
        .exmem_rd       (exmem_rd),
        .exmem_RegWrite (exmem_RegWrite),
        .exmem_ALUout   (exmem_ALUout),
        .memwb_rd       (memwb_rd),
        .memwb_RegWrite (memwb_RegWrite),
        .memwb_Result   (memwb_Result),
        .data           (op1_fwd)
    );

    forward_unit #(.DW(DATA_WIDTH), .AW(REG_AW)) u_fwd_rs2 (
        .rs             (ex_rs2),
        .rf_data        (ex_rd2),
        .exmem_rd       (exmem_rd),
        .exmem_RegWrite (exmem_RegWrite),
        .exmem_ALUout   (exmem_ALUout),
        .memwb_rd       (memwb_rd),
        .memwb_RegWrite (memwb_RegWrite),
        .memwb_Result   (memwb_Result),
        .data           (op2_fwd)
    );
`else
    // Result buses are only consumed by the forwarding muxes
    logic unused_results;
    assign unused_results = ^{exmem_ALUout, memwb_Result};
    assign op1_fwd = ex_rd1;
    assign op2_fwd = ex_rd2;
`endif

    assign ALUop1       = op1_fwd;
    assign ALUop2       = ex_ALUsrc ? ex_imm : op2_fwd;
    assign ex_StoreData = op2_fwd;

endmodule
